// File: rtl/cmp_serial_pm.sv
`default_nettype none
// ============================================================================
// Module   : cmp_serial_pm
// Purpose  : Iterative MSB-first magnitude comparator. Scans DIGIT bits per
//            clock and stops at the first differing digit. The relation
//            (EQ/NE/LT/LE/GT/GE) and signedness are chosen per job.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid/in_ready  - operand handshake (a, b, mode, is_signed)
//            out_valid/out_ready - result handshake (result, ncyc)
//            ncyc               - number of scan cycles used (1..N)
// Revision : 1.0 - initial release
// ============================================================================
module cmp_serial_pm #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic [2:0]                        mode,
    input  logic                              is_signed,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              result,
    output logic [$clog2(WIDTH/DIGIT):0]      ncyc
);

    localparam int N   = WIDTH / DIGIT;
    localparam int NCW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [NCW-1:0] C_LAST = NCW'(N - 1);
    localparam logic [NCW-1:0] C_ONE  = NCW'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_mode;
    logic [NCW-1:0]   r_cnt;
    logic [NCW-1:0]   r_ncyc;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;

    logic [DIGIT-1:0] w_dig_a;
    logic [DIGIT-1:0] w_dig_b;
    logic             w_rel;

    // The operands are shifted left each equal digit, so the digit under
    // test is always the top one.
    assign w_dig_a = r_a[WIDTH-1 -: DIGIT];
    assign w_dig_b = r_b[WIDTH-1 -: DIGIT];

    always_comb begin
        w_rel = 1'b0;
        case (r_mode)
            3'd0:    w_rel = r_eq;
            3'd1:    w_rel = !r_eq;
            3'd2:    w_rel = r_lt;
            3'd3:    w_rel = r_lt | r_eq;
            3'd4:    w_rel = r_gt;
            3'd5:    w_rel = r_gt | r_eq;
            default: w_rel = 1'b0;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    // Gated so the output reads 0 whenever no result is being offered.
    assign result    = (r_state == S_DONE) && w_rel;
    assign ncyc      = r_ncyc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= '0;
            r_cnt   <= '0;
            r_ncyc  <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Flipping the sign bit maps two's complement onto
                        // offset binary, so the scan itself is always unsigned.
                        r_a     <= {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
                        r_b     <= {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};
                        r_mode  <= mode;
                        r_cnt   <= '0;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_dig_a != w_dig_b) begin
                        r_gt    <= (w_dig_a > w_dig_b);
                        r_lt    <= !(w_dig_a > w_dig_b);
                        r_eq    <= 1'b0;
                        r_ncyc  <= r_cnt + C_ONE;
                        r_state <= S_DONE;
                    end else if (r_cnt == C_LAST) begin
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b1;
                        r_ncyc  <= r_cnt + C_ONE;
                        r_state <= S_DONE;
                    end else begin
                        r_a     <= r_a << DIGIT;
                        r_b     <= r_b << DIGIT;
                        r_cnt   <= r_cnt + C_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_serial_pm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_serial_pm
// Purpose  : Self-checking bench for cmp_serial_pm. Two instances:
//            WIDTH=8/DIGIT=2 for directed jobs, WIDTH=4/DIGIT=1 for an
//            exhaustive unsigned LE sweep. Expected results are queued when
//            a job is issued and popped when the DUT offers its result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_serial_pm;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid8, in_valid4;
    logic       out_ready;
    logic       is_signed;
    logic [2:0] mode;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;

    logic       in_ready8, out_valid8, result8;
    logic [2:0] ncyc8;
    logic       in_ready4, out_valid4, result4;
    logic [2:0] ncyc4;

    cmp_serial_pm #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .mode(mode), .is_signed(is_signed),
        .out_valid(out_valid8), .out_ready(out_ready),
        .result(result8), .ncyc(ncyc8)
    );

    cmp_serial_pm #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .mode(mode), .is_signed(is_signed),
        .out_valid(out_valid4), .out_ready(out_ready),
        .result(result4), .ncyc(ncyc4)
    );

    typedef struct {
        logic res;
        int   ncyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one job, wait for its result, compare against the scoreboard,
    // optionally hold off the consumer for 'hold' cycles, then check release.
    task automatic job(input bit w4, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] m, input logic s, input int hold,
                       input logic er, input int en);
        exp_t e;
        int   lat;
        bit   seen;
        logic r0;
        logic [2:0] n0;
        e.res  = er;
        e.ncyc = en;
        sb.push_back(e);
        @(negedge clk);
        check("in_ready_idle", w4 ? in_ready4 : in_ready8, 1);
        if (w4) begin
            a4 = a[3:0]; b4 = b[3:0]; in_valid4 = 1'b1;
        end else begin
            a8 = a; b8 = b; in_valid8 = 1'b1;
        end
        mode      = m;
        is_signed = s;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
        // Disturb the operand inputs; the job in flight must ignore them.
        a8 = ~a8; b8 = ~b8; a4 = ~a4; b4 = 4'h0;
        mode = 3'd1; is_signed = ~s;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = w4 ? out_valid4 : out_valid8;
        end
        check("out_valid_seen", seen, 1);
        e  = sb.pop_front();
        r0 = w4 ? result4 : result8;
        n0 = w4 ? ncyc4 : ncyc8;
        check("result", r0, e.res);
        check("ncyc", n0, e.ncyc);
        check("latency", lat, e.ncyc + 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", w4 ? out_valid4 : out_valid8, 1);
            check("hold_result", w4 ? result4 : result8, e.res);
            check("hold_ncyc", w4 ? ncyc4 : ncyc8, e.ncyc);
            check("hold_in_ready", w4 ? in_ready4 : in_ready8, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", w4 ? in_ready4 : in_ready8, 1);
        check("release_out_valid", w4 ? out_valid4 : out_valid8, 0);
    endtask

    initial begin
        int  lead;
        bit  any_valid;
        logic [3:0] ea, eb;
        rst_n = 1'b0; in_valid8 = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
        is_signed = 1'b0; mode = 3'd0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid8, 0);
        check("rst_result", result8, 0);
        check("rst_ncyc", ncyc8, 0);
        check("rst_in_ready", in_ready8, 1);
        check("rst4_in_ready", in_ready4, 1);

        // Equal operands scan all four digits.
        job(1'b0, 8'h35, 8'h35, 3'd3, 1'b0, 0, 1'b1, 4);
        job(1'b0, 8'h35, 8'h35, 3'd1, 1'b0, 0, 1'b0, 4);
        // MSB digit decides; signedness flips the outcome.
        job(1'b0, 8'hC0, 8'h3F, 3'd4, 1'b0, 0, 1'b1, 1);
        job(1'b0, 8'hC0, 8'h3F, 3'd4, 1'b1, 0, 1'b0, 1);
        job(1'b0, 8'hC0, 8'h3F, 3'd2, 1'b1, 0, 1'b1, 1);
        // Backpressure: last digit decides, consumer stalls 3 cycles.
        job(1'b0, 8'h12, 8'h13, 3'd2, 1'b0, 3, 1'b1, 4);
        // Reserved modes.
        job(1'b0, 8'h12, 8'h34, 3'd6, 1'b0, 0, 1'b0, 2);
        job(1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 0, 1'b0, 4);
        // Signed extremes.
        job(1'b0, 8'h80, 8'h7F, 3'd2, 1'b1, 0, 1'b1, 1);
        job(1'b0, 8'hFF, 8'hFF, 3'd5, 1'b1, 0, 1'b1, 4);
        job(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 0, 1'b1, 4);
        job(1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 0, 1'b1, 4);

        // Reset in the middle of a scan discards the job.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'hAA; mode = 3'd0; is_signed = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid8, 0);
        check("midrst_result", result8, 0);
        check("midrst_ncyc", ncyc8, 0);
        check("midrst_in_ready", in_ready8, 1);
        any_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid8) any_valid = 1'b1;
        end
        check("midrst_no_result", any_valid, 0);
        job(1'b0, 8'h5A, 8'h5B, 3'd5, 1'b0, 0, 1'b0, 4);

        // Exhaustive 4-bit unsigned LE, one bit per scan cycle.
        for (int i = 0; i < 256; i++) begin
            ea = i[7:4];
            eb = i[3:0];
            lead = 0;
            for (int j = 3; j >= 0; j--) begin
                if (ea[j] != eb[j]) break;
                lead++;
            end
            job(1'b1, {4'h0, ea}, {4'h0, eb}, 3'd3, 1'b0, 0,
                (ea <= eb), (lead + 1 > 4) ? 4 : lead + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
